// File: rtl/programmable_clock_divider_if.sv
// Configuration port bundle for the
// programmable clock divider.
interface programmable_clock_divider_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_high;
  logic             cfg_load;
  logic             cfg_pending;
  logic             cfg_ack;

  modport master (
    output cfg_period,
    output cfg_high,
    output cfg_load,
    input  cfg_pending,
    input  cfg_ack
  );

  modport slave (
    input  cfg_period,
    input  cfg_high,
    input  cfg_load,
    output cfg_pending,
    output cfg_ack
  );
endinterface

// File: rtl/programmable_clock_divider.sv
// Programmable clock divider with shadowed
// period/high-time config applied at wrap.
module programmable_clock_divider #(
  parameter int WIDTH      = 8,
  parameter int RST_PERIOD = 16,
  parameter int RST_HIGH   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  programmable_clock_divider_if.slave cfg,
  output logic out_clk,
  output logic tick
);

  localparam logic [WIDTH-1:0] RP =
    WIDTH'(RST_PERIOD);
  localparam logic [WIDTH-1:0] RH =
    WIDTH'(RST_HIGH);
  localparam logic [WIDTH-1:0] MIN_P =
    WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] shp_q, shp_d;
  logic [WIDTH-1:0] shh_q, shh_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;

  logic [WIDTH-1:0] clp_per;
  logic [WIDTH-1:0] clp_hi;
  logic             last;

  // Clamp incoming config to a legal shape
  always_comb begin
    clp_per = cfg.cfg_period;
    if (cfg.cfg_period < MIN_P)
      clp_per = MIN_P;
    clp_hi = cfg.cfg_high;
    if (cfg.cfg_high > clp_per)
      clp_hi = clp_per;
  end

  assign last = (state_q == RUN) &&
                (cnt_q == per_q - ONE);

  // Next-state, counter and config apply
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    hi_d    = hi_q;
    shp_d   = shp_q;
    shh_d   = shh_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_q) begin
          per_d  = shp_q;
          hi_d   = shh_q;
          pend_d = 1'b0;
          ack_d  = 1'b1;
        end
        if (cfg.cfg_load) begin
          shp_d  = clp_per;
          shh_d  = clp_hi;
          pend_d = 1'b1;
        end
        if (en)
          state_d = RUN;
      end
      RUN: begin
        if (!last) begin
          cnt_d = cnt_q + ONE;
          if (cfg.cfg_load) begin
            shp_d  = clp_per;
            shh_d  = clp_hi;
            pend_d = 1'b1;
          end
        end else begin
          cnt_d = '0;
          if (cfg.cfg_load) begin
            per_d  = clp_per;
            hi_d   = clp_hi;
            pend_d = 1'b0;
            ack_d  = 1'b1;
          end else if (pend_q) begin
            per_d  = shp_q;
            hi_d   = shh_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
          end
          if (!en)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= RP;
      hi_q    <= RH;
      shp_q   <= RP;
      shh_q   <= RH;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      shp_q   <= shp_d;
      shh_q   <= shh_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
    end
  end

  assign out_clk = (state_q == RUN) &&
                   (cnt_q >= per_q - hi_q);
  assign tick = last;

  assign cfg.cfg_pending = pend_q;
  assign cfg.cfg_ack     = ack_q;

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Scoreboard bench for the programmable
// clock divider with a behavioural model.
module tb_programmable_clock_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic out_clk;
  logic tick;

  programmable_clock_divider_if #(
    .WIDTH(W)
  ) cif ();

  programmable_clock_divider #(
    .WIDTH(W),
    .RST_PERIOD(16),
    .RST_HIGH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cfg(cif),
    .out_clk(out_clk),
    .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic o;
    logic t;
    logic p;
    logic a;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Model: running flag, position inside
  // the current period, active and waiting
  // period/high settings.
  bit m_run;
  int m_pos;
  int m_per;
  int m_hi;
  int m_sp;
  int m_sh;
  bit m_pend;
  bit m_ack;

  function automatic void m_reset();
    m_run  = 1'b0;
    m_pos  = 0;
    m_per  = 16;
    m_hi   = 8;
    m_sp   = 16;
    m_sh   = 8;
    m_pend = 1'b0;
    m_ack  = 1'b0;
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    e.o = m_run && (m_pos >= m_per - m_hi);
    e.t = m_run && (m_pos == m_per - 1);
    e.p = m_pend;
    e.a = m_ack;
    return e;
  endfunction

  function automatic void m_step(
    input bit e,
    input bit l,
    input int p,
    input int h
  );
    int cp;
    int ch;
    bit at_end;
    cp = (p < 2) ? 2 : p;
    ch = (h > cp) ? cp : h;
    at_end = m_run && (m_pos == m_per - 1);
    m_ack = 1'b0;
    if (!m_run) begin
      if (m_pend) begin
        m_per = m_sp;
        m_hi = m_sh;
        m_pend = 1'b0;
        m_ack = 1'b1;
      end
      if (l) begin
        m_sp = cp;
        m_sh = ch;
        m_pend = 1'b1;
      end
      m_pos = 0;
      m_run = e;
    end else if (!at_end) begin
      m_pos = m_pos + 1;
      if (l) begin
        m_sp = cp;
        m_sh = ch;
        m_pend = 1'b1;
      end
    end else begin
      m_pos = 0;
      if (l) begin
        m_per = cp;
        m_hi = ch;
        m_pend = 1'b0;
        m_ack = 1'b1;
      end else if (m_pend) begin
        m_per = m_sp;
        m_hi = m_sh;
        m_pend = 1'b0;
        m_ack = 1'b1;
      end
      m_run = e;
    end
  endfunction

  task automatic drive_cycle(
    input bit r,
    input bit e,
    input bit l,
    input int p,
    input int h
  );
    @(negedge clk);
    rst = r;
    en = e;
    cif.cfg_load = l;
    cif.cfg_period = p[W-1:0];
    cif.cfg_high = h[W-1:0];
    if (!r) m_reset();
    else m_step(e, l, p, h);
    sb.push_back(m_out());
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++)
      drive_cycle(1'b1, e, 1'b0, 0, 0);
  endtask

  task automatic wait_pos(input int tgt);
    int g = 0;
    while (!(m_run && m_pos == tgt) &&
           g < 300) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
      g++;
    end
  endtask

  task automatic check_rst_now(
    input string name
  );
    vectors++;
    if (out_clk !== 1'b0 || tick !== 1'b0 ||
        cif.cfg_pending !== 1'b0 ||
        cif.cfg_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got o=%b t=%b p=%b a=%b want 0000",
               name, out_clk, tick,
               cif.cfg_pending, cif.cfg_ack);
    end
  endtask

  task automatic async_rst();
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    sb.push_back(m_out());
    #1;
    check_rst_now("async_reset");
    drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);
    drive_cycle(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  // Monitor: compare one expectation per edge
  initial begin
    exp_t e;
    exp_t g;
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = {out_clk, tick,
             cif.cfg_pending, cif.cfg_ack};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL cyc%0d o/t/p/a: got %b want %b",
                   cyc, g, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    en = 1'b0;
    cif.cfg_load = 1'b0;
    cif.cfg_period = '0;
    cif.cfg_high = '0;
    m_reset();
    #1;
    check_rst_now("power_on_reset");
    drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);
    drive_cycle(1'b1, 1'b0, 1'b0, 0, 0);

    // Default 16/8 divide
    run(40, 1'b1);

    // Load 5/2 mid-period at cnt=4
    wait_pos(4);
    drive_cycle(1'b1, 1'b1, 1'b1, 5, 2);
    run(40, 1'b1);

    // Drop enable at cnt=3, then restart
    async_rst();
    wait_pos(3);
    run(20, 1'b0);
    run(20, 1'b1);

    // Clamp in idle: 1/9 -> 2/2
    async_rst();
    drive_cycle(1'b1, 1'b0, 1'b1, 1, 9);
    run(4, 1'b0);
    run(10, 1'b1);

    // Load 6/0 exactly on a wrap edge
    wait_pos(m_per - 1);
    drive_cycle(1'b1, 1'b1, 1'b1, 6, 0);
    run(20, 1'b1);

    // Reset at cnt=12 with load pending
    async_rst();
    wait_pos(4);
    drive_cycle(1'b1, 1'b1, 1'b1, 5, 3);
    wait_pos(12);
    async_rst();
    run(20, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      drive_cycle(
        $urandom_range(0, 199) != 0,
        $urandom_range(0, 9) != 0,
        $urandom_range(0, 7) == 0,
        int'($urandom_range(0, 20)),
        int'($urandom_range(0, 22)));
    end
    run(5, 1'b1);

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d left want 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/programmable_clock_divider.md
PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the period/high-time counters and config ports.
REQ-002 Parameter RST_PERIOD, default 16: active period (in clk cycles) loaded at reset, range 2..2^WIDTH-1.
REQ-003 Parameter RST_HIGH, default 8: active high-time loaded at reset, range 0..RST_PERIOD.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-006 en  input  1  run enable.
REQ-007 cfg_period  input  WIDTH  requested period in clk cycles.
REQ-008 cfg_high  input  WIDTH  requested high-time in clk cycles.
REQ-009 cfg_load  input  1  strobe; captures cfg_period/cfg_high on the rising edge where it is 1.
REQ-010 cfg_pending  output  1  captured config is waiting to be applied.
REQ-011 cfg_ack  output  1  one-cycle pulse: config applied.
REQ-012 out_clk  output  1  divided clock.
REQ-013 tick  output  1  one-cycle pulse on the last cycle of each period.

Function
REQ-014 Registers: period_r, high_r (active), shadow period/high, cnt (WIDTH bits), state in {IDLE, RUN}.
REQ-015 Capture clamping: period < 2 -> 2; high > clamped period -> clamped period; clamped values stored in shadow.
REQ-016 cfg_load=1 -> shadow updated, cfg_pending=1 from next cycle; repeated cfg_load while pending overwrites shadow (last wins).
REQ-017 IDLE: cnt=0, out_clk=0, tick=0; pending shadow applied on the next edge, cfg_pending->0, cfg_ack=1 for one cycle.
REQ-018 IDLE with en=1 -> RUN on next edge with cnt=0.
REQ-019 RUN, cnt != period_r-1: cnt <= cnt+1.
REQ-020 RUN, cnt == period_r-1 (wrap): cnt <= 0; pending shadow copied to period_r/high_r, cfg_pending->0, cfg_ack=1 the following cycle.
REQ-021 Wrap edge with cfg_load=1: clamped cfg inputs applied directly to period_r/high_r, shadow bypassed, cfg_pending=0, cfg_ack=1 next cycle.
REQ-022 cfg_load in any other RUN cycle never alters the period in progress.
REQ-023 out_clk = (state==RUN) && (cnt >= period_r-high_r), decoded from registers only; low phase first, then high phase.
REQ-024 high_r=0 -> out_clk constant 0; high_r=period_r -> constant 1 while RUN.
REQ-025 tick = (state==RUN) && (cnt==period_r-1), decoded from registers only.
REQ-026 en=0 in RUN: current period completes; at wrap -> IDLE (pending config still applied at that wrap). en back to 1 before wrap -> RUN continues uninterrupted.
REQ-027 No combinational path from any input to out_clk or tick.

Reset
REQ-028 rst=0 immediately, without clk: state=IDLE, cnt=0, period_r=RST_PERIOD, high_r=RST_HIGH, shadow=reset values, cfg_pending=0, cfg_ack=0, out_clk=0, tick=0.
REQ-029 Reset mid-period discards any pending config; after rst=1, operation restarts from IDLE per REQ-018.

Verification
REQ-030 Reset, en=1, defaults -> out_clk 0 for 8 cycles then 1 for 8, repeating; tick once per 16 cycles, on cnt=15.
REQ-031 RUN at cnt=4, cfg_load period=5 high=2 -> current 16-cycle period unchanged; cfg_ack after wrap; then out_clk 0,0,0,1,1 repeating, tick every 5.
REQ-032 cfg_load period=1 high=9 in IDLE -> applied as period=2 high=2; en=1 -> out_clk constant 1, tick every 2 cycles.
REQ-033 Defaults, en dropped at cnt=3 -> counts to 15, tick, then IDLE with out_clk=0; en=1 again -> restarts at cnt=0.
REQ-034 rst=0 at cnt=12 (out_clk=1) with a load pending -> out_clk=0 and cfg_pending=0 before next clk edge; period back to 16.
REQ-035 cfg_load high=0 period=6 on a wrap edge -> cfg_ack next cycle, out_clk stays 0, tick every 6 cycles.
